// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART frame receiver. Samples a pre-synchronised
// serial line at mid-bit using an oversampling tick counter. Handles optional
// even/odd parity and one or two stop bits. Reports good frames, parity
// errors, framing errors and line breaks as one-cycle registered pulses.
module uart_rx_param #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 signal,
   output logic                 valid,
   output logic [DATA_BITS-1:0] data,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 break_det,
   output logic                 busy
);

   localparam int HALF   = (CLKS_PER_BIT - 1) / 2;
   localparam int TICK_W = $clog2(CLKS_PER_BIT + 1);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(HALF);
   localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic              HAS_PAR   = (PARITY_EN != 0);
   localparam logic              ODD_PAR   = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t               state_q;
   logic [TICK_W-1:0]    tick_q;
   logic [BIT_W-1:0]     bitCnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 parBit_q;
   logic                 stopBad_q;
   logic                 valid_q;
   logic                 parityErr_q;
   logic                 frameErr_q;
   logic                 breakDet_q;

   logic [TICK_W-1:0]    tickDec_d;
   logic                 stopBad_d;
   logic                 parityOk_d;
   logic                 lineDead_d;

   // Per-cycle decodes shared by the receive state machine: decremented tick,
   // running stop-bit verdict, parity verdict and "whole frame was low".
   always_comb begin
      tickDec_d  = tick_q - 1'b1;
      stopBad_d  = stopBad_q | ~signal;
      parityOk_d = (((^shift_q) ^ parBit_q) == ODD_PAR);
      lineDead_d = (shift_q == '0) && !(HAS_PAR && parBit_q);
   end

   // Receive state machine. The start-detection edge already counts as the
   // first of the HALF cycles, so START acts when the decremented tick hits
   // zero; this lands every sample HALF + n*CLKS_PER_BIT cycles after detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         tick_q      <= '0;
         bitCnt_q    <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         parBit_q    <= 1'b0;
         stopBad_q   <= 1'b0;
         valid_q     <= 1'b0;
         parityErr_q <= 1'b0;
         frameErr_q  <= 1'b0;
         breakDet_q  <= 1'b0;
      end else begin
         valid_q     <= 1'b0;
         parityErr_q <= 1'b0;
         frameErr_q  <= 1'b0;
         breakDet_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!signal) begin
                  bitCnt_q  <= '0;
                  stopBad_q <= 1'b0;
                  if (HALF == 0) begin
                     state_q <= S_DATA;
                     tick_q  <= TICK_FULL;
                  end else begin
                     state_q <= S_START;
                     tick_q  <= TICK_HALF;
                  end
               end
            end
            S_START: begin
               tick_q <= tickDec_d;
               if (tickDec_d == '0) begin
                  if (signal) begin
                     state_q <= S_IDLE;
                  end else begin
                     state_q <= S_DATA;
                     tick_q  <= TICK_FULL;
                  end
               end
            end
            S_DATA: begin
               if (tick_q == '0) begin
                  shift_q <= {signal, shift_q[DATA_BITS-1:1]};
                  tick_q  <= TICK_FULL;
                  if (bitCnt_q == DATA_LAST) begin
                     bitCnt_q <= '0;
                     if (HAS_PAR) begin
                        state_q <= S_PARITY;
                     end else begin
                        state_q <= S_STOP;
                     end
                  end else begin
                     bitCnt_q <= bitCnt_q + 1'b1;
                  end
               end else begin
                  tick_q <= tickDec_d;
               end
            end
            S_PARITY: begin
               if (tick_q == '0) begin
                  parBit_q <= signal;
                  tick_q   <= TICK_FULL;
                  state_q  <= S_STOP;
               end else begin
                  tick_q <= tickDec_d;
               end
            end
            S_STOP: begin
               if (tick_q == '0) begin
                  if (bitCnt_q == STOP_LAST) begin
                     bitCnt_q  <= '0;
                     stopBad_q <= 1'b0;
                     if (stopBad_d) begin
                        frameErr_q <= 1'b1;
                        breakDet_q <= lineDead_d;
                        state_q    <= S_WAIT_HIGH;
                     end else if (HAS_PAR && !parityOk_d) begin
                        parityErr_q <= 1'b1;
                        state_q     <= S_IDLE;
                     end else begin
                        valid_q <= 1'b1;
                        data_q  <= shift_q;
                        state_q <= S_IDLE;
                     end
                  end else begin
                     stopBad_q <= stopBad_d;
                     bitCnt_q  <= bitCnt_q + 1'b1;
                     tick_q    <= TICK_FULL;
                  end
               end else begin
                  tick_q <= tickDec_d;
               end
            end
            S_WAIT_HIGH: begin
               if (signal) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign valid      = valid_q;
   assign data       = data_q;
   assign parity_err = parityErr_q;
   assign frame_err  = frameErr_q;
   assign break_det  = breakDet_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: exercises four differently parametrised receivers. Line
// waveforms are built one cycle per entry. A waveform-level frame parser
// predicts every output on every cycle.
`timescale 1ns/1ps
module tb_uart_rx_param;

   localparam int NI = 4;
   localparam int DB0 = 8, CPB0 = 1, PE0 = 0, PO0 = 0, SB0 = 1;
   localparam int DB1 = 8, CPB1 = 4, PE1 = 1, PO1 = 0, SB1 = 1;
   localparam int DB2 = 7, CPB2 = 1, PE2 = 0, PO2 = 0, SB2 = 2;
   localparam int DB3 = 5, CPB3 = 3, PE3 = 1, PO3 = 1, SB3 = 2;

   int cfgDb  [NI] = '{DB0, DB1, DB2, DB3};
   int cfgCpb [NI] = '{CPB0, CPB1, CPB2, CPB3};
   int cfgPe  [NI] = '{PE0, PE1, PE2, PE3};
   int cfgPo  [NI] = '{PO0, PO1, PO2, PO3};
   int cfgSb  [NI] = '{SB0, SB1, SB2, SB3};

   logic clk = 1'b0;
   logic rstN   [NI];
   logic lineS  [NI];
   logic validS [NI];
   logic perrS  [NI];
   logic ferrS  [NI];
   logic brkS   [NI];
   logic busyS  [NI];
   logic [DB0-1:0] data0;
   logic [DB1-1:0] data1;
   logic [DB2-1:0] data2;
   logic [DB3-1:0] data3;

   int nCompared   = 0;
   int nMismatched = 0;

   // Line waveform, per-cycle expectations and per-run observations.
   bit         wave[$];
   bit         eV[$], eP[$], eF[$], eB[$], eBusy[$];
   logic [8:0] eData[$];
   logic [8:0] mData [NI];
   int         obsV, obsP, obsF, obsB, obsVB;
   int         vCyc[$];
   logic [8:0] vDat[$];
   bit         obsBusy[$];

   typedef struct {
      int         inst;
      logic [8:0] payload;
      bit         parBit;
      bit [1:0]   stops;
      bit         xV, xP, xF, xB;
      logic [8:0] xData;
      string      name;
   } vec_t;
   vec_t vecs[$];

   uart_rx_param #(.DATA_BITS(DB0), .CLKS_PER_BIT(CPB0), .PARITY_EN(PE0),
                   .PARITY_ODD(PO0), .STOP_BITS(SB0)) dut0 (
      .clk(clk), .reset(rstN[0]), .signal(lineS[0]), .valid(validS[0]), .data(data0),
      .parity_err(perrS[0]), .frame_err(ferrS[0]), .break_det(brkS[0]), .busy(busyS[0]));
   uart_rx_param #(.DATA_BITS(DB1), .CLKS_PER_BIT(CPB1), .PARITY_EN(PE1),
                   .PARITY_ODD(PO1), .STOP_BITS(SB1)) dut1 (
      .clk(clk), .reset(rstN[1]), .signal(lineS[1]), .valid(validS[1]), .data(data1),
      .parity_err(perrS[1]), .frame_err(ferrS[1]), .break_det(brkS[1]), .busy(busyS[1]));
   uart_rx_param #(.DATA_BITS(DB2), .CLKS_PER_BIT(CPB2), .PARITY_EN(PE2),
                   .PARITY_ODD(PO2), .STOP_BITS(SB2)) dut2 (
      .clk(clk), .reset(rstN[2]), .signal(lineS[2]), .valid(validS[2]), .data(data2),
      .parity_err(perrS[2]), .frame_err(ferrS[2]), .break_det(brkS[2]), .busy(busyS[2]));
   uart_rx_param #(.DATA_BITS(DB3), .CLKS_PER_BIT(CPB3), .PARITY_EN(PE3),
                   .PARITY_ODD(PO3), .STOP_BITS(SB3)) dut3 (
      .clk(clk), .reset(rstN[3]), .signal(lineS[3]), .valid(validS[3]), .data(data3),
      .parity_err(perrS[3]), .frame_err(ferrS[3]), .break_det(brkS[3]), .busy(busyS[3]));

   // Free-running system clock, 10 ns period.
   always #5 clk = ~clk;

   // Hard time limit so a stuck run still terminates.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] time limit expired");
   end

   function automatic logic [8:0] getData(input int inst);
      case (inst)
         0:       return {1'b0, data0};
         1:       return {1'b0, data1};
         2:       return {2'b0, data2};
         default: return {4'b0, data3};
      endcase
   endfunction

   task automatic checkOutput(input string name, input int inst,
                              input logic [8:0] act, input logic [8:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s inst%0d: got %0h want %0h", name, inst, act, exp);
      end
   endtask

   task automatic appendLevel(input bit b, input int n);
      for (int i = 0; i < n; i++) wave.push_back(b);
   endtask

   task automatic appendFrame(input int inst, input logic [8:0] payload, input bit pb,
                              input bit [1:0] stops, input int gap);
      appendLevel(1'b0, cfgCpb[inst]);
      for (int k = 0; k < cfgDb[inst]; k++) appendLevel(payload[k], cfgCpb[inst]);
      if (cfgPe[inst] != 0) appendLevel(pb, cfgCpb[inst]);
      for (int s = 0; s < cfgSb[inst]; s++) appendLevel(stops[s], cfgCpb[inst]);
      appendLevel(1'b1, gap);
   endtask

   function automatic int tailLen(input int inst);
      return (cfgDb[inst] + cfgPe[inst] + cfgSb[inst] + 3) * cfgCpb[inst] + 4;
   endfunction

   task automatic markBusy(input int a, input int b);
      for (int i = a; i <= b && i < eBusy.size(); i++) eBusy[i] = 1'b1;
   endtask

   // Frame parser over the whole waveform: a low level seen while idle starts
   // a frame. Sample n lands HALF + n*CLKS_PER_BIT cycles later (n=0 is the
   // start bit). Index i holds what the outputs show after clock edge i.
   task automatic buildExpect(input int inst);
      int n, db, cpb, half, pe, sb, t, base, last, k;
      logic [8:0] pay, cur;
      bit pb, bad;
      n = wave.size(); db = cfgDb[inst]; cpb = cfgCpb[inst]; half = (cpb - 1) / 2;
      pe = cfgPe[inst]; sb = cfgSb[inst];
      cur = mData[inst];
      eV.delete(); eP.delete(); eF.delete(); eB.delete(); eBusy.delete(); eData.delete();
      for (int i = 0; i < n; i++) begin
         eV.push_back(1'b0); eP.push_back(1'b0); eF.push_back(1'b0);
         eB.push_back(1'b0); eBusy.push_back(1'b0); eData.push_back(cur);
      end
      t = 0;
      while (t < n) begin
         if (wave[t]) begin
            t++;
         end else if (t + half >= n) begin
            markBusy(t, n - 1); t = n;
         end else if (wave[t + half]) begin
            markBusy(t, t + half - 1); t = t + half + 1;
         end else begin
            base = t + half;
            last = base + (db + pe + sb) * cpb;
            if (last >= n) begin
               markBusy(t, n - 1); t = n;
            end else begin
               pay = '0;
               for (int j = 0; j < db; j++) pay[j] = wave[base + (j + 1) * cpb];
               pb = (pe != 0) ? wave[base + (db + 1) * cpb] : 1'b0;
               bad = 1'b0;
               for (int s = 0; s < sb; s++)
                  if (!wave[base + (db + pe + 1 + s) * cpb]) bad = 1'b1;
               markBusy(t, last - 1);
               if (bad) begin
                  eF[last] = 1'b1;
                  eB[last] = (pay == 0) && !pb;
                  k = last + 1;
                  while (k < n && !wave[k]) k++;
                  markBusy(last, k - 1);
                  t = k + 1;
               end else if (pe != 0 && (((^pay) ^ pb) != (cfgPo[inst] != 0))) begin
                  eP[last] = 1'b1; t = last + 1;
               end else begin
                  eV[last] = 1'b1; cur = pay;
                  for (int i = last; i < n; i++) eData[i] = cur;
                  t = last + 1;
               end
            end
         end
      end
      mData[inst] = cur;
   endtask

   // Plays the waveform one entry per cycle (driven at negedge, sampled by the
   // DUT at posedge) and compares every output at the following negedge.
   task automatic applyStimulus(input int inst, input string tag);
      buildExpect(inst);
      obsV = 0; obsP = 0; obsF = 0; obsB = 0; obsVB = 0;
      vCyc.delete(); vDat.delete(); obsBusy.delete();
      for (int i = 0; i < wave.size(); i++) begin
         lineS[inst] = wave[i];
         @(posedge clk);
         @(negedge clk);
         checkOutput({tag, "-valid"}, inst, 9'(validS[inst]), 9'(eV[i]));
         checkOutput({tag, "-perr"},  inst, 9'(perrS[inst]),  9'(eP[i]));
         checkOutput({tag, "-ferr"},  inst, 9'(ferrS[inst]),  9'(eF[i]));
         checkOutput({tag, "-brk"},   inst, 9'(brkS[inst]),   9'(eB[i]));
         checkOutput({tag, "-busy"},  inst, 9'(busyS[inst]),  9'(eBusy[i]));
         checkOutput({tag, "-data"},  inst, getData(inst),    eData[i]);
         if (validS[inst]) begin
            obsV++; vCyc.push_back(i); vDat.push_back(getData(inst));
         end
         if (perrS[inst]) obsP++;
         if (ferrS[inst]) obsF++;
         if (brkS[inst]) obsB++;
         if (ferrS[inst] && brkS[inst]) obsVB++;
         obsBusy.push_back(busyS[inst]);
      end
      lineS[inst] = 1'b1;
   endtask

   task automatic addVec(input int inst, input logic [8:0] payload, input bit pb,
                         input bit [1:0] stops, input bit xv, input bit xp, input bit xf,
                         input bit xb, input logic [8:0] xd, input string name);
      vec_t v;
      v.inst = inst; v.payload = payload; v.parBit = pb; v.stops = stops;
      v.xV = xv; v.xP = xp; v.xF = xf; v.xB = xb; v.xData = xd; v.name = name;
      vecs.push_back(v);
   endtask

   // Main test sequence.
   initial begin
      logic [8:0] pay, mask;
      bit         pb;
      bit [1:0]   st;

      for (int i = 0; i < NI; i++) begin
         rstN[i] = 1'b0; lineS[i] = 1'b1; mData[i] = '0;
      end

      // Frame table: expected outcome and data after each frame, in order.
      addVec(0, 9'h055, 1'b0, 2'b01, 1, 0, 0, 0, 9'h055, "a55");
      addVec(0, 9'h0AB, 1'b0, 2'b00, 0, 0, 1, 0, 9'h055, "aStopLow");
      addVec(0, 9'h000, 1'b0, 2'b00, 0, 0, 1, 1, 9'h055, "aBreak");
      addVec(0, 9'h000, 1'b0, 2'b01, 1, 0, 0, 0, 9'h000, "aZero");
      addVec(1, 9'h0B6, 1'b1, 2'b01, 1, 0, 0, 0, 9'h0B6, "bB6");
      addVec(1, 9'h0B6, 1'b0, 2'b01, 0, 1, 0, 0, 9'h0B6, "bB6par");
      addVec(1, 9'h000, 1'b0, 2'b00, 0, 0, 1, 1, 9'h0B6, "bBreak");
      addVec(1, 9'h000, 1'b1, 2'b00, 0, 0, 1, 0, 9'h0B6, "bParHigh");
      addVec(1, 9'h03C, 1'b1, 2'b00, 0, 0, 1, 0, 9'h0B6, "bFrmOverPar");
      addVec(2, 9'h02A, 1'b0, 2'b11, 1, 0, 0, 0, 9'h02A, "c2A");
      addVec(2, 9'h015, 1'b0, 2'b01, 0, 0, 1, 0, 9'h02A, "cStop2Low");
      addVec(2, 9'h015, 1'b0, 2'b10, 0, 0, 1, 0, 9'h02A, "cStop1Low");
      addVec(3, 9'h013, 1'b0, 2'b11, 1, 0, 0, 0, 9'h013, "d13");
      addVec(3, 9'h013, 1'b1, 2'b11, 0, 1, 0, 0, 9'h013, "d13par");
      addVec(3, 9'h00A, 1'b1, 2'b11, 1, 0, 0, 0, 9'h00A, "d0A");

      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checkOutput("rst-valid", i, 9'(validS[i]), 9'd0);
         checkOutput("rst-perr",  i, 9'(perrS[i]),  9'd0);
         checkOutput("rst-ferr",  i, 9'(ferrS[i]),  9'd0);
         checkOutput("rst-brk",   i, 9'(brkS[i]),   9'd0);
         checkOutput("rst-busy",  i, 9'(busyS[i]),  9'd0);
         checkOutput("rst-data",  i, getData(i),    9'd0);
         rstN[i] = 1'b1;
      end
      @(negedge clk);

      for (int v = 0; v < vecs.size(); v++) begin
         wave.delete();
         appendFrame(vecs[v].inst, vecs[v].payload, vecs[v].parBit, vecs[v].stops, 0);
         appendLevel(1'b1, tailLen(vecs[v].inst));
         applyStimulus(vecs[v].inst, vecs[v].name);
         checkOutput({vecs[v].name, "-nValid"}, vecs[v].inst, 9'(obsV), 9'(vecs[v].xV));
         checkOutput({vecs[v].name, "-nPerr"},  vecs[v].inst, 9'(obsP), 9'(vecs[v].xP));
         checkOutput({vecs[v].name, "-nFerr"},  vecs[v].inst, 9'(obsF), 9'(vecs[v].xF));
         checkOutput({vecs[v].name, "-nBrk"},   vecs[v].inst, 9'(obsB), 9'(vecs[v].xB));
         checkOutput({vecs[v].name, "-dataEnd"}, vecs[v].inst, getData(vecs[v].inst), vecs[v].xData);
      end

      // Framing error, line held low, then a good all-zero frame.
      wave.delete();
      appendFrame(0, 9'h0AB, 1'b0, 2'b00, 0);
      appendLevel(1'b0, 3);
      appendLevel(1'b1, 2);
      appendFrame(0, 9'h000, 1'b0, 2'b01, 0);
      appendLevel(1'b1, tailLen(0));
      applyStimulus(0, "lowHold");
      checkOutput("lowHold-nValid", 0, 9'(obsV), 9'd1);
      checkOutput("lowHold-nFerr",  0, 9'(obsF), 9'd1);
      checkOutput("lowHold-data",   0, getData(0), 9'h000);

      // Line stuck low: break with framing error, busy until the line recovers.
      wave.delete();
      appendLevel(1'b0, 14);
      appendLevel(1'b1, 4);
      applyStimulus(0, "break");
      checkOutput("break-nBoth", 0, 9'(obsVB), 9'd1);
      checkOutput("break-nBrk",  0, 9'(obsB), 9'd1);
      checkOutput("break-busyLow", 0, 9'(obsBusy[12]), 9'd1);
      checkOutput("break-busyEnd", 0, 9'(obsBusy[17]), 9'd0);

      // Single-cycle low glitch on an idle oversampled line.
      wave.delete();
      appendLevel(1'b1, 2);
      appendLevel(1'b0, 1);
      appendLevel(1'b1, 10);
      applyStimulus(1, "glitch");
      checkOutput("glitch-nFlags", 1, 9'(obsV + obsP + obsF), 9'd0);
      checkOutput("glitch-busyStart", 1, 9'(obsBusy[2]), 9'd1);
      checkOutput("glitch-busyDrop",  1, 9'(obsBusy[3]), 9'd0);

      // Asynchronous reset in the middle of data bit 5, then a clean frame.
      wave.delete();
      appendFrame(1, 9'h05A, 1'b0, 2'b01, 0);
      while (wave.size() > 6 * CPB1 + 2) void'(wave.pop_back());
      applyStimulus(1, "preRst");
      #2;
      rstN[1] = 1'b0;
      #1;
      checkOutput("midRst-valid", 1, 9'(validS[1]), 9'd0);
      checkOutput("midRst-perr",  1, 9'(perrS[1]),  9'd0);
      checkOutput("midRst-ferr",  1, 9'(ferrS[1]),  9'd0);
      checkOutput("midRst-brk",   1, 9'(brkS[1]),   9'd0);
      checkOutput("midRst-busy",  1, 9'(busyS[1]),  9'd0);
      checkOutput("midRst-data",  1, getData(1),    9'd0);
      @(negedge clk);
      rstN[1] = 1'b1;
      mData[1] = '0;
      wave.delete();
      appendFrame(1, 9'h05A, 1'b0, 2'b01, 0);
      appendLevel(1'b1, tailLen(1));
      applyStimulus(1, "postRst");
      checkOutput("postRst-nValid", 1, 9'(obsV), 9'd1);
      checkOutput("postRst-data",   1, getData(1), 9'h05A);

      // Back-to-back 7-bit frames with two stop bits and no idle gap.
      wave.delete();
      appendFrame(2, 9'h02A, 1'b0, 2'b11, 0);
      appendFrame(2, 9'h015, 1'b0, 2'b11, 0);
      appendLevel(1'b1, tailLen(2));
      applyStimulus(2, "b2b");
      checkOutput("b2b-nValid", 2, 9'(obsV), 9'd2);
      if (vCyc.size() == 2) begin
         checkOutput("b2b-gap",   2, 9'(vCyc[1] - vCyc[0]), 9'd10);
         checkOutput("b2b-data0", 2, vDat[0], 9'h02A);
         checkOutput("b2b-data1", 2, vDat[1], 9'h015);
      end

      // Randomised frame streams with occasional parity, stop and break faults.
      for (int inst = 0; inst < NI; inst++) begin
         wave.delete();
         mask = 9'((1 << cfgDb[inst]) - 1);
         for (int f = 0; f < 20; f++) begin
            pay = 9'($urandom) & mask;
            pb  = (^pay) ^ (cfgPo[inst] != 0);
            if ($urandom_range(0, 4) == 0) pb = ~pb;
            st  = 2'b11;
            if ($urandom_range(0, 4) == 0) st = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) begin
               pay = '0; pb = 1'b0; st = 2'b00;
            end
            appendFrame(inst, pay, pb, st, $urandom_range(0, 3));
         end
         appendLevel(1'b1, tailLen(inst));
         applyStimulus(inst, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised UART frame receiver; successor to the fixed 8N1, one-sample-per-clock uart FSM.
- Adds:
  - configurable data width, stop-bit count and oversampling ratio
  - optional even/odd parity
  - received data output, framing/parity error flags, break detection
- Sits directly behind the serial input pin; feeds a byte-wide consumer through a one-cycle valid strobe.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first; legal 5..9.
- CLKS_PER_BIT, 1, clock cycles per bit period; 1 = one sample per clock, legacy behaviour.
- PARITY_EN, 0, 1 = parity bit follows data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, stop bits checked; legal 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets.
- signal  input  1  serial line; idle high; pre-synchronised.
- valid  output  1  one-cycle pulse: good frame received, data updated.
- data  output  DATA_BITS  last good frame payload, bit 0 = first received.
- parity_err  output  1  one-cycle pulse: stop bits good, parity mismatch.
- frame_err  output  1  one-cycle pulse: any stop-bit sample low.
- break_det  output  1  one-cycle pulse, coincident with frame_err: whole frame low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all counters and shift register cleared
  - valid=0, data=0, parity_err=0, frame_err=0, break_det=0, busy=0
  - any frame in progress is discarded; after release, receiver waits for a fresh start bit.
- Counters:
  - HALF = (CLKS_PER_BIT-1)/2, integer division.
  - tick counter width $clog2(CLKS_PER_BIT+1); bit counter width $clog2(DATA_BITS+1).
- States:
  - IDLE:
    - signal=0 sampled is the start detection; load tick=HALF.
    - If HALF=0, go to DATA with tick=CLKS_PER_BIT-1; else go to START.
  - START:
    - Decrement tick each cycle.
    - At tick=0 (mid start bit): signal=0 -> DATA, tick=CLKS_PER_BIT-1; signal=1 -> IDLE (glitch, no flags).
  - DATA:
    - Decrement tick each cycle.
    - At tick=0: shift signal in LSB-first, bit_cnt+1, reload tick=CLKS_PER_BIT-1.
    - After DATA_BITS samples: PARITY if PARITY_EN, else STOP.
  - PARITY: at tick=0, capture parity bit, reload tick, go to STOP.
  - STOP:
    - At tick=0, sample one stop bit; repeat STOP_BITS times.
    - Any low stop sample marks a framing error.
- Sample timing:
  - With CLKS_PER_BIT=1, data bit k is sampled k+1 cycles after start detection.
  - In general, every sample lands HALF + n*CLKS_PER_BIT cycles after start detection.
- Completion: outputs are registered and appear the cycle after the final stop sample.
  - Stop good, parity good or disabled: valid=1, data=payload; next state IDLE.
  - Stop good, parity bad: parity_err=1, data unchanged, valid=0; next state IDLE.
  - Stop bad: frame_err=1, valid=0, data unchanged, parity not reported.
    - break_det=1 additionally if payload=0 and captured parity bit (when enabled) =0.
    - Next state WAIT_HIGH.
- WAIT_HIGH: stay until signal=1 sampled, then IDLE; no new start is detected while the line stays low.
- Back-to-back frames: the IDLE entered after a good stop may detect a new start on its first cycle; no idle gap required.
- valid, parity_err and frame_err are mutually exclusive.
- data holds its value between valid pulses.
- Parity check:
  - even: XOR(payload, parity bit) must be 0.
  - odd: XOR(payload, parity bit) must be 1.

Test Plan:
- Defaults; reset low 1 cycle, then frame start 0, data 1,0,1,0,1,0,1,0, stop 1 -> valid pulses 1 cycle after stop sample, data=8'h55; no error flags.
- Defaults; frame 0, 1,1,0,1,0,1,0,1, stop 0 -> frame_err=1, valid=0, break_det=0, data unchanged.
  - Then hold line low 3 cycles, raise high, send good frame with all-zero data -> only the good frame gives valid, data=8'h00.
- Defaults; start followed immediately by line low for 9 cycles -> frame_err=1 and break_det=1 together.
  - busy stays high until line returns high.
- CLKS_PER_BIT=4, PARITY_EN=1, PARITY_ODD=0:
  - each bit held 4 cycles, data 8'hB6 with parity 1 -> valid, data=8'hB6.
  - same data with parity 0 -> parity_err=1 only, data stays 8'hB6.
- CLKS_PER_BIT=4; 1-cycle low glitch on idle line -> START rejects at mid-bit, returns to IDLE, no flags.
  - Also: assert reset=0 mid-data bit 5 of a frame -> all outputs 0 immediately, next full frame received correctly.
- Defaults, DATA_BITS=7, STOP_BITS=2:
  - two back-to-back 7-bit frames 7'h2A, 7'h15 with no gap -> two valid pulses 10 cycles apart, data 7'h2A then 7'h15.
  - second stop bit low -> frame_err.
